ram_tdp_csoe_be: RTL and testbench

Parametrised true-dual-port synchronous RAM with chip-select and output-enable per port. It is the next generation of the team's CS/OE TDP RAM and adds the following:
- per-byte write enables
- independent writes on both ports in the same cycle
- a selectable read-during-write mode
- a selectable read latency of 1 or 2 cycles
- read-valid strobes
- collision flags
- an optional post-reset memory-clear sequencer
It sits between bus-side masters and local datapath buffers, one master per port.

---
 rtl/ram_tdp_pkg.sv | 16 +
 rtl/ram_tdp_rd_pipe.sv | 46 ++++
 rtl/ram_tdp_csoe_be.sv | 167 ++++++++++++++++
 tb/tb_ram_tdp_csoe_be.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_tdp_pkg.sv
// Shared types and constants for the CS/OE true-dual-port RAM with byte enables.
package ram_tdp_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } clr_state_t;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    localparam int unsigned COLL_WW = 0;
    localparam int unsigned COLL_RW = 1;

endpackage

// File: rtl/ram_tdp_rd_pipe.sv
// Per-port read pipeline: stage-1 capture plus optional second stage, holding data when idle.
module ram_tdp_rd_pipe #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DWIDTH-1:0] word,
    output logic [DWIDTH-1:0] dout,
    output logic              dvld
);

    logic [DWIDTH-1:0] s1_dat;
    logic              s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin : stage1
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= req;
            if (req) begin
                s1_dat <= word;
            end
        end
    end

    if (RD_LAT >= 2) begin : g_lat2
        always_ff @(posedge clk or negedge rst_n) begin : stage2
            if (!rst_n) begin
                dvld <= 1'b0;
                dout <= '0;
            end else begin
                dvld <= s1_vld;
                if (s1_vld) begin
                    dout <= s1_dat;
                end
            end
        end
    end else begin : g_lat1
        assign dout = s1_dat;
        assign dvld = s1_vld;
    end

endmodule

// File: rtl/ram_tdp_csoe_be.sv
// True-dual-port RAM with chip select, output enable, byte enables, collision flags
// and a post-reset clear sequencer.
module ram_tdp_csoe_be
    import ram_tdp_pkg::*;
#(
    parameter int unsigned       DWIDTH     = 32,
    parameter int unsigned       AWIDTH     = 4,
    parameter int unsigned       RDEPTH     = 1 << AWIDTH,
    parameter int unsigned       BEWIDTH    = DWIDTH / 8,
    parameter int unsigned       RD_LAT     = 1,
    parameter int unsigned       RDW_MODE   = 0,
    parameter int unsigned       CLR_ON_RST = 1,
    parameter logic [DWIDTH-1:0] CLR_VAL    = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs_0,
    input  logic               oe_0,
    input  logic               we_0,
    input  logic [BEWIDTH-1:0] be_0,
    input  logic [AWIDTH-1:0]  addr_0,
    input  logic [DWIDTH-1:0]  din_0,
    output logic [DWIDTH-1:0]  dout_0,
    output logic               dvld_0,
    input  logic               cs_1,
    input  logic               oe_1,
    input  logic               we_1,
    input  logic [BEWIDTH-1:0] be_1,
    input  logic [AWIDTH-1:0]  addr_1,
    input  logic [DWIDTH-1:0]  din_1,
    output logic [DWIDTH-1:0]  dout_1,
    output logic               dvld_1,
    output logic               init_busy,
    output logic [1:0]         coll
);

    logic [DWIDTH-1:0] mem [RDEPTH];

    clr_state_t        state;
    logic [AWIDTH-1:0] clr_cnt;

    logic              in_rng_0, in_rng_1;
    logic              rd_0, rd_1, wr_0, wr_1, same_addr;
    logic [DWIDTH-1:0] word_0, word_1, rword_0, rword_1;

    function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0]  old_w,
                                                      input logic [DWIDTH-1:0]  new_w,
                                                      input logic [BEWIDTH-1:0] be);
        logic [DWIDTH-1:0] res;
        res = old_w;
        for (int unsigned i = 0; i < BEWIDTH; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Only a non-power-of-two depth needs an address range check.
    if (RDEPTH >= (1 << AWIDTH)) begin : g_full
        assign in_rng_0 = 1'b1;
        assign in_rng_1 = 1'b1;
    end else begin : g_part
        assign in_rng_0 = (addr_0 < AWIDTH'(RDEPTH));
        assign in_rng_1 = (addr_1 < AWIDTH'(RDEPTH));
    end

    always_comb begin : req_qual
        rd_0      = cs_0 & oe_0 & ~init_busy;
        rd_1      = cs_1 & oe_1 & ~init_busy;
        wr_0      = cs_0 & we_0 & ~init_busy & in_rng_0 & (|be_0);
        wr_1      = cs_1 & we_1 & ~init_busy & in_rng_1 & (|be_1);
        same_addr = (addr_0 == addr_1);
        word_0    = in_rng_0 ? mem[addr_0] : '0;
        word_1    = in_rng_1 ? mem[addr_1] : '0;
        rword_0   = word_0;
        rword_1   = word_1;
        // Write-first returns only this port's own merge, never the other port's write.
        if (RDW_MODE == RDW_NEW) begin
            if (wr_0) begin
                rword_0 = merge_bytes(word_0, din_0, be_0);
            end
            if (wr_1) begin
                rword_1 = merge_bytes(word_1, din_1, be_1);
            end
        end
    end

    // Port 0 lanes are assigned last so they win on a same-address collision.
    always_ff @(posedge clk) begin : mem_wr
        if (state == CLEAR) begin
            mem[clr_cnt] <= CLR_VAL;
        end else begin
            for (int unsigned i = 0; i < BEWIDTH; i++) begin
                if (wr_1 && be_1[i]) begin
                    mem[addr_1][8*i +: 8] <= din_1[8*i +: 8];
                end
                if (wr_0 && be_0[i]) begin
                    mem[addr_0][8*i +: 8] <= din_0[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : coll_reg
        if (!rst_n) begin
            coll <= '0;
        end else begin
            coll[COLL_WW] <= wr_0 & wr_1 & same_addr & (|(be_0 & be_1));
            coll[COLL_RW] <= same_addr & ((rd_0 & wr_1) | (rd_1 & wr_0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : clr_fsm
        if (!rst_n) begin
            state     <= INIT;
            clr_cnt   <= '0;
            init_busy <= (CLR_ON_RST != 0);
        end else begin
            case (state)
                INIT: begin
                    if (CLR_ON_RST != 0) begin
                        state <= CLEAR;
                    end else begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == AWIDTH'(RDEPTH - 1)) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + AWIDTH'(1);
                    end
                end
                READY:   state <= READY;
                default: state <= INIT;
            endcase
        end
    end

    ram_tdp_rd_pipe #(
        .DWIDTH (DWIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_0 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_0),
        .word  (rword_0),
        .dout  (dout_0),
        .dvld  (dvld_0)
    );

    ram_tdp_rd_pipe #(
        .DWIDTH (DWIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_1),
        .word  (rword_1),
        .dout  (dout_1),
        .dvld  (dvld_1)
    );

endmodule

// File: tb/tb_ram_tdp_csoe_be.sv
// Scoreboard bench: two RAM instances (latency 1 / read-first, latency 2 / write-first)
// driven with identical stimulus and checked against a behavioural memory model.
module tb_ram_tdp_csoe_be;

    localparam logic [31:0] CLR_A = 32'hA5A5A5A5;
    localparam logic [31:0] CLR_B = 32'h00000000;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs_0, oe_0, we_0, cs_1, oe_1, we_1;
    logic [3:0]  be_0, be_1, addr_0, addr_1;
    logic [31:0] din_0, din_1;

    logic [31:0] dout_a0, dout_a1, dout_b0, dout_b1;
    logic        dvld_a0, dvld_a1, dvld_b0, dvld_b1, busy_a, busy_b;
    logic [1:0]  coll_a, coll_b;

    exp_t        q_rd [4][$];
    exp_t        q_coll [2][$];
    logic [31:0] mdl [2][16];
    exp_t        e_mon;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          mbusy = 0;

    ram_tdp_csoe_be #(.RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1), .CLR_VAL(CLR_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cs_0(cs_0), .oe_0(oe_0), .we_0(we_0), .be_0(be_0), .addr_0(addr_0), .din_0(din_0),
        .dout_0(dout_a0), .dvld_0(dvld_a0),
        .cs_1(cs_1), .oe_1(oe_1), .we_1(we_1), .be_1(be_1), .addr_1(addr_1), .din_1(din_1),
        .dout_1(dout_a1), .dvld_1(dvld_a1),
        .init_busy(busy_a), .coll(coll_a)
    );

    ram_tdp_csoe_be #(.RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1), .CLR_VAL(CLR_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cs_0(cs_0), .oe_0(oe_0), .we_0(we_0), .be_0(be_0), .addr_0(addr_0), .din_0(din_0),
        .dout_0(dout_b0), .dvld_0(dvld_b0),
        .cs_1(cs_1), .oe_1(oe_1), .we_1(we_1), .be_1(be_1), .addr_1(addr_1), .din_1(din_1),
        .dout_1(dout_b1), .dvld_1(dvld_b1),
        .init_busy(busy_b), .coll(coll_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        end
        return r;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic p0(input logic cs, input logic oe, input logic we, input logic [3:0] be,
                      input logic [3:0] a, input logic [31:0] d);
        cs_0 = cs; oe_0 = oe; we_0 = we; be_0 = be; addr_0 = a; din_0 = d;
    endtask

    task automatic p1(input logic cs, input logic oe, input logic we, input logic [3:0] be,
                      input logic [3:0] a, input logic [31:0] d);
        cs_1 = cs; oe_1 = oe; we_1 = we; be_1 = be; addr_1 = a; din_1 = d;
    endtask

    task automatic idle();
        p0(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        p1(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    // Model one clock of traffic: queue expected reads/collisions, then update the model memory.
    task automatic step();
        logic        busy, rd0, rd1, wr0, wr1, same;
        logic [31:0] r0, r1;
        exp_t        e;
        busy = (mbusy > 0);
        if (busy) mbusy--;
        rd0  = cs_0 & oe_0 & !busy;
        rd1  = cs_1 & oe_1 & !busy;
        wr0  = cs_0 & we_0 & !busy & (be_0 != 4'h0);
        wr1  = cs_1 & we_1 & !busy & (be_1 != 4'h0);
        same = (addr_0 == addr_1);
        for (int d = 0; d < 2; d++) begin
            r0 = mdl[d][addr_0];
            r1 = mdl[d][addr_1];
            if (d == 1 && wr0) r0 = merge(r0, din_0, be_0);
            if (d == 1 && wr1) r1 = merge(r1, din_1, be_1);
            if (rd0) begin e.data = r0; e.due = cyc + lat_of(d); q_rd[d*2].push_back(e); end
            if (rd1) begin e.data = r1; e.due = cyc + lat_of(d); q_rd[d*2+1].push_back(e); end
            e.data = {30'd0, same & ((rd0 & wr1) | (rd1 & wr0)),
                      wr0 & wr1 & same & ((be_0 & be_1) != 4'h0)};
            e.due  = cyc + 1;
            q_coll[d].push_back(e);
            if (wr1) mdl[d][addr_1] = merge(mdl[d][addr_1], din_1, be_1);
            if (wr0) mdl[d][addr_0] = merge(mdl[d][addr_0], din_0, be_0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) q_rd[k].delete();
        for (int d = 0; d < 2; d++) q_coll[d].delete();
    endtask

    task automatic check_zero_outs();
        chk("rst_dout_a0", dout_a0, 32'h0);
        chk("rst_dout_a1", dout_a1, 32'h0);
        chk("rst_dout_b0", dout_b0, 32'h0);
        chk("rst_dout_b1", dout_b1, 32'h0);
        chk("rst_dvld_a", {30'd0, dvld_a1, dvld_a0}, 32'h0);
        chk("rst_dvld_b", {30'd0, dvld_b1, dvld_b0}, 32'h0);
        chk("rst_coll_a", {30'd0, coll_a}, 32'h0);
        chk("rst_coll_b", {30'd0, coll_b}, 32'h0);
        chk("rst_busy", {30'd0, busy_b, busy_a}, 32'h3);
    endtask

    // Assert reset (async), check cleared outputs, release on a clock boundary.
    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        #1;
        check_zero_outs();
        flush();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mbusy = 17;
        for (int a = 0; a < 16; a++) begin
            mdl[0][a] = CLR_A;
            mdl[1][a] = CLR_B;
        end
    endtask

    // Count busy cycles after release; a write issued in the first busy cycle must be lost.
    task automatic wait_clear();
        int na, nb;
        na = 0;
        nb = 0;
        p0(1'b1, 1'b0, 1'b1, 4'hF, 4'h1, 32'h12345678);
        for (int i = 0; i < 40 && (busy_a || busy_b); i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            step();
            idle();
        end
        chk("busy_len_a", 32'(na), 32'd17);
        chk("busy_len_b", 32'(nb), 32'd17);
    endtask

    logic [3:0]  dv;
    logic [31:0] dq [4];
    logic [1:0]  cl [2];
    assign dv    = {dvld_b1, dvld_b0, dvld_a1, dvld_a0};
    assign dq[0] = dout_a0;
    assign dq[1] = dout_a1;
    assign dq[2] = dout_b0;
    assign dq[3] = dout_b1;
    assign cl[0] = coll_a;
    assign cl[1] = coll_b;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (q_rd[k].size() != 0 && q_rd[k][0].due == cyc) begin
                    e_mon = q_rd[k].pop_front();
                    chk($sformatf("dvld[%0d]", k), 32'(dv[k]), 32'd1);
                    chk($sformatf("dout[%0d]", k), dq[k], e_mon.data);
                end else if (dv[k] === 1'b1) begin
                    chk($sformatf("dvld_spurious[%0d]", k), 32'(dv[k]), 32'd0);
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (q_coll[d].size() != 0 && q_coll[d][0].due == cyc) begin
                    e_mon = q_coll[d].pop_front();
                    chk($sformatf("coll[%0d]", d), {30'd0, cl[d]}, e_mon.data);
                end
            end
        end
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        apply_reset();
        wait_clear();

        // Cleared contents and the write lost during busy.
        p0(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
        p1(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 32'h0);
        step();
        p0(1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 32'h0);
        idle_p1();
        step();

        // Full write then a single byte lane, read back on the other port.
        idle();
        p0(1'b1, 1'b0, 1'b1, 4'hF, 4'h3, 32'h11223344);
        step();
        p0(1'b1, 1'b0, 1'b1, 4'h2, 4'h3, 32'hFFFFFFFF);
        step();
        idle();
        p1(1'b1, 1'b1, 1'b0, 4'h0, 4'h3, 32'h0);
        step();

        // Same-address write-write with overlapping lanes.
        idle();
        p0(1'b1, 1'b0, 1'b1, 4'h3, 4'h5, 32'hAAAAAAAA);
        p1(1'b1, 1'b0, 1'b1, 4'h6, 4'h5, 32'hBBBBBBBB);
        step();
        idle();
        p1(1'b1, 1'b1, 1'b0, 4'h0, 4'h5, 32'h0);
        step();

        // Read-during-write on port 0 plus cross-port read of the same word.
        idle();
        p0(1'b1, 1'b1, 1'b1, 4'hF, 4'h7, 32'hDEADBEEF);
        p1(1'b1, 1'b1, 1'b0, 4'h0, 4'h7, 32'h0);
        step();

        // Both collision kinds at once; zero byte-enable write is no write.
        idle();
        p0(1'b1, 1'b1, 1'b1, 4'h1, 4'h9, 32'h01020304);
        p1(1'b1, 1'b0, 1'b1, 4'h1, 4'h9, 32'h0A0B0C0D);
        step();
        p0(1'b1, 1'b0, 1'b1, 4'h0, 4'hA, 32'hFFFFFFFF);
        p1(1'b1, 1'b1, 1'b0, 4'h0, 4'hA, 32'h0);
        step();

        // Back-to-back reads on port 1, then idle so dout must hold the last word.
        idle();
        for (int a = 0; a < 3; a++) begin
            p1(1'b1, 1'b1, 1'b0, 4'h0, 4'(a), 32'h0);
            step();
        end
        idle();
        repeat (4) step();
        chk("hold_a1", dout_a1, mdl[0][2]);
        chk("hold_b1", dout_b1, mdl[1][2]);

        // Random traffic over a narrow address window to provoke collisions.
        for (int i = 0; i < 150; i++) begin
            p0(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 4'($urandom),
               4'($urandom_range(0, 5)), $urandom);
            p1(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 4'($urandom),
               4'($urandom_range(0, 5)), $urandom);
            step();
        end
        idle();
        repeat (4) step();

        // Reset while reads and a collision are in flight.
        p0(1'b1, 1'b1, 1'b1, 4'hF, 4'h4, 32'h55667788);
        p1(1'b1, 1'b1, 1'b1, 4'hF, 4'h4, 32'h99AABBCC);
        step();
        apply_reset();

        // Reset again partway through the clear; the clear must restart.
        repeat (9) step();
        apply_reset();
        wait_clear();
        p0(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 32'h0);
        p1(1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 32'h0);
        step();
        p0(1'b1, 1'b1, 1'b0, 4'h0, 4'h8, 32'h0);
        p1(1'b1, 1'b1, 1'b0, 4'h0, 4'h4, 32'h0);
        step();
        idle();
        repeat (4) step();

        for (int k = 0; k < 4; k++) chk($sformatf("drain_rd[%0d]", k), 32'(q_rd[k].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic idle_p1();
        p1(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

endmodule
